// File: rtl/fsm_responder_pkg.sv
// fsm_responder_pkg: shared types and constants for the fsm_responder target.
// Optional build macro used by this slice: FSM_RESPONDER_RAND_WAIT_EN.
package fsm_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_RD  = 2'd0,
      OP_WR  = 2'd1,
      OP_ERR = 2'd2
   } op_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/fsm_responder_lfsr.sv
// resp_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise wait states.
// The module only exists when FSM_RESPONDER_RAND_WAIT_EN is defined, so the
// default build carries no LFSR logic at all.
`ifdef FSM_RESPONDER_RAND_WAIT_EN
module resp_lfsr
   import fsm_responder_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   output logic [7:0] q
);

   logic feedback;

   assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

   // Shift left every edge, feeding the tap parity into bit 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q <= LFSR_SEED;
      end else begin
         q <= {q[6:0], feedback};
      end
   end

endmodule
`endif

// File: rtl/fsm_responder.sv
// fsm_responder: target-side responder for the idle/read/write request FSM.
// Samples a request from IDLE, waits WAIT_CYCLES, then performs the access on
// a small register array and returns a one-cycle ack (plus err for read+write).
// Define FSM_RESPONDER_RAND_WAIT_EN to add 0..3 pseudo-random extra wait states.
module fsm_responder
   import fsm_responder_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(WAIT_CYCLES + 5);

   state_t            state;
   op_t               op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  load_val;
   logic              req;
   logic [DATA_W-1:0] mem [DEPTH];

   assign req  = read | write;
   assign busy = (state != IDLE);

`ifdef FSM_RESPONDER_RAND_WAIT_EN
   logic [7:0] lfsr_q;

   resp_lfsr u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .q      (lfsr_q)
   );

   assign load_val = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr_q[1:0]);
`else
   assign load_val = CNT_W'(WAIT_CYCLES);
`endif

   // Request FSM: sample in IDLE, count wait states, respond from ACK, then hold in DONE until strobes drop.
   // The ack/err/rdata registers are loaded on the edge that leaves ACK, which places ack
   // WAIT_CYCLES+1 edges after the sampling edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt     <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  if (read && write) begin
                     op_q <= OP_ERR;
                  end else if (read) begin
                     op_q <= OP_RD;
                  end else begin
                     op_q <= OP_WR;
                  end
                  cnt   <= load_val;
                  state <= (load_val == '0) ? ACK : WAIT;
               end
            end
            WAIT: begin
               if (!req) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt <= CNT_W'(1)) begin
                     state <= ACK;
                  end
               end
            end
            ACK: begin
               ack <= 1'b1;
               if (op_q == OP_RD) begin
                  rdata <= mem[addr_q];
               end
               if (op_q == OP_ERR) begin
                  err <= 1'b1;
               end
               state <= DONE;
            end
            DONE: begin
               if (!req) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Register array: cleared by reset, written only when a write completes from ACK.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == ACK && op_q == OP_WR) begin
         mem[addr_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_fsm_responder.sv
// tb_fsm_responder: directed self-checking bench for fsm_responder
// (WAIT_CYCLES=2, FSM_RESPONDER_RAND_WAIT_EN undefined).
module tb_fsm_responder;

   logic       clk;
   logic       resetn;
   logic       read;
   logic       write;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic       ack;
   logic [7:0] rdata;
   logic       busy;
   logic       err;

   int compared;
   int mismatched;

   fsm_responder #(
      .ADDR_W      (4),
      .DATA_W      (8),
      .WAIT_CYCLES (2)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .read   (read),
      .write  (write),
      .addr   (addr),
      .wdata  (wdata),
      .ack    (ack),
      .rdata  (rdata),
      .busy   (busy),
      .err    (err)
   );

   // Free-running 10-unit clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One full access starting and ending on a falling edge; ack must appear
   // exactly three rising edges after the sampling edge.
   task automatic apply_stimulus(input string tag, input logic rd, input logic wr,
                                 input logic [3:0] a, input logic [7:0] d,
                                 input logic exp_err, input logic [7:0] exp_rdata);
      read  = rd;
      write = wr;
      addr  = a;
      wdata = d;
      @(negedge clk);
      check_output({tag, "/busy_e0"}, busy, 1);
      check_output({tag, "/ack_e0"}, ack, 0);
      addr  = ~a;
      wdata = ~d;
      @(negedge clk);
      check_output({tag, "/ack_e1"}, ack, 0);
      @(negedge clk);
      check_output({tag, "/ack_e2"}, ack, 0);
      check_output({tag, "/busy_e2"}, busy, 1);
      @(negedge clk);
      check_output({tag, "/ack_e3"}, ack, 1);
      check_output({tag, "/err_e3"}, err, exp_err);
      check_output({tag, "/rdata_e3"}, rdata, exp_rdata);
      check_output({tag, "/busy_e3"}, busy, 1);
      read  = 1'b0;
      write = 1'b0;
      @(negedge clk);
      check_output({tag, "/ack_e4"}, ack, 0);
      check_output({tag, "/err_e4"}, err, 0);
      check_output({tag, "/busy_e4"}, busy, 0);
      check_output({tag, "/rdata_hold"}, rdata, exp_rdata);
   endtask

   // Directed sequence covering reset, write, read-back, abort, error and reset-in-flight.
   initial begin
      compared   = 0;
      mismatched = 0;
      resetn = 1'b0;
      read   = 1'b0;
      write  = 1'b0;
      addr   = 4'h0;
      wdata  = 8'h00;

      @(negedge clk);
      @(negedge clk);
      check_output("rst/ack", ack, 0);
      check_output("rst/busy", busy, 0);
      check_output("rst/err", err, 0);
      check_output("rst/rdata", rdata, 8'h00);
      resetn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_output("idle/ack", ack, 0);
         check_output("idle/busy", busy, 0);
         check_output("idle/err", err, 0);
         check_output("idle/rdata", rdata, 8'h00);
      end

      apply_stimulus("wr3", 1'b0, 1'b1, 4'h3, 8'h5A, 1'b0, 8'h00);
      apply_stimulus("rd3", 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 8'h5A);
      apply_stimulus("rd7", 1'b1, 1'b0, 4'h7, 8'h00, 1'b0, 8'h00);

      // Abort: write strobe dropped while the responder is still waiting.
      write = 1'b1;
      addr  = 4'h1;
      wdata = 8'hFF;
      @(negedge clk);
      check_output("abort/busy", busy, 1);
      write = 1'b0;
      @(negedge clk);
      check_output("abort/busy_idle", busy, 0);
      check_output("abort/ack0", ack, 0);
      @(negedge clk);
      check_output("abort/ack1", ack, 0);
      @(negedge clk);
      check_output("abort/ack2", ack, 0);
      apply_stimulus("rd1", 1'b1, 1'b0, 4'h1, 8'h00, 1'b0, 8'h00);

      // Error: read and write together must ack with err, leave rdata and the array alone.
      apply_stimulus("rd3b", 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 8'h5A);
      apply_stimulus("err3", 1'b1, 1'b1, 4'h3, 8'h11, 1'b1, 8'h5A);
      apply_stimulus("rd3c", 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 8'h5A);

      // Reset asserted while a write to 4'h2 is waiting.
      write = 1'b1;
      addr  = 4'h2;
      wdata = 8'h77;
      @(negedge clk);
      check_output("rstwait/busy", busy, 1);
      #2;
      resetn = 1'b0;
      #1;
      check_output("rstwait/ack", ack, 0);
      check_output("rstwait/busy0", busy, 0);
      check_output("rstwait/err", err, 0);
      check_output("rstwait/rdata", rdata, 8'h00);
      write = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("rstwait/noack", ack, 0);
         check_output("rstwait/idle", busy, 0);
      end
      apply_stimulus("rd2", 1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 8'h00);
      apply_stimulus("rd3d", 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
